// File: rtl/mem_request_issuer_if.sv
// Memory request bus between the request issuer (master) and the N-core memory controller (slave).
// Carries the MRead/MWrite/MReady handshake plus the per-lane mask, address, write and read data.
interface mem_request_issuer_if #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
);
   logic                MRead;
   logic                MWrite;
   logic                MReady;
   logic [N_CORES-1:0]  en;
   logic [ADDR_W-1:0]   addr [N_CORES];
   logic [DATA_W-1:0]   data [N_CORES];
   logic [DATA_W-1:0]   q    [N_CORES];

   modport master (output MRead, MWrite, en, addr, data, input MReady, q);
   modport slave  (input MRead, MWrite, en, addr, data, output MReady, q);
endinterface

// File: rtl/mem_request_issuer.sv
// Initiator side of the MRead/MWrite/MReady handshake: latches one load/store per core lane,
// pulses the request for one cycle, holds the bus until MReady and reports done/timeout.
module mem_request_issuer #(
   parameter int N_CORES        = 4,
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                is_store,
   input  logic [N_CORES-1:0]  core_en,
   input  logic [ADDR_W-1:0]   core_addr  [N_CORES],
   input  logic [DATA_W-1:0]   core_wdata [N_CORES],
   output logic                busy,
   output logic                done,
   output logic                timeout_err,
   output logic [DATA_W-1:0]   rdata      [N_CORES],
   mem_request_issuer_if.master mem
);
   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q;
   logic                 is_store_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 terr_q;
   logic                 mread_q;
   logic                 mwrite_q;
   logic [N_CORES-1:0]   en_q;
   logic [ADDR_W-1:0]    addr_q  [N_CORES];
   logic [DATA_W-1:0]    data_q  [N_CORES];
   logic [DATA_W-1:0]    rdata_q [N_CORES];
   logic [CNT_W-1:0]     cnt_q;

   logic [CNT_W-1:0]     cnt_d;
   logic [DATA_W-1:0]    rdata_d [N_CORES];
   logic                 timeout_hit_s;

   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = terr_q;
   assign rdata       = rdata_q;
   assign mem.MRead   = mread_q;
   assign mem.MWrite  = mwrite_q;
   assign mem.en      = en_q;
   assign mem.addr    = addr_q;
   assign mem.data    = data_q;

   // Load capture: lanes in the latched mask take the controller's data, the rest keep their value.
   always_comb begin
      for (int i = 0; i < N_CORES; i++) begin
         if (en_q[i] && !is_store_q) begin
            rdata_d[i] = mem.q[i];
         end else begin
            rdata_d[i] = rdata_q[i];
         end
      end
   end

   // Wait counter increment and the abort condition on its final count.
   always_comb begin
      cnt_d         = cnt_q + CNT_W'(1'b1);
      timeout_hit_s = (cnt_q == CNT_LAST);
   end

   // Request FSM with all bus and status outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         is_store_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         terr_q     <= 1'b0;
         mread_q    <= 1'b0;
         mwrite_q   <= 1'b0;
         en_q       <= {N_CORES{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         for (int i = 0; i < N_CORES; i++) begin
            addr_q[i]  <= {ADDR_W{1'b0}};
            data_q[i]  <= {DATA_W{1'b0}};
            rdata_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  is_store_q <= is_store;
                  addr_q     <= core_addr;
                  data_q     <= core_wdata;
                  terr_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  // An empty mask never touches the controller.
                  if (core_en == {N_CORES{1'b0}}) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     en_q     <= core_en;
                     mread_q  <= ~is_store;
                     mwrite_q <= is_store;
                     state_q  <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // MReady seen here belongs to an earlier request and is ignored.
               mread_q  <= 1'b0;
               mwrite_q <= 1'b0;
               cnt_q    <= {CNT_W{1'b0}};
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               if (mem.MReady) begin
                  rdata_q <= rdata_d;
                  en_q    <= {N_CORES{1'b0}};
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (timeout_hit_s) begin
                  terr_q  <= 1'b1;
                  en_q    <= {N_CORES{1'b0}};
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q  <= S_IDLE;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
               mread_q  <= 1'b0;
               mwrite_q <= 1'b0;
               en_q     <= {N_CORES{1'b0}};
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_request_issuer.sv
// Directed bench for mem_request_issuer: a behavioural memory controller, a cycle-timeline
// reference model checked every cycle, and literal expectations for each scenario.
module tb_mem_request_issuer;
   localparam int NC = 4;
   localparam int TO = 16;
   typedef logic [15:0] lane_t [NC];

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic           is_store = 1'b0;
   logic [NC-1:0]  core_en = 4'b0000;
   lane_t          core_addr, core_wdata, rdata;
   logic           busy, done, timeout_err;

   mem_request_issuer_if #(.N_CORES(NC), .ADDR_W(16), .DATA_W(16)) mif ();

   mem_request_issuer #(.N_CORES(NC), .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store), .core_en(core_en),
      .core_addr(core_addr), .core_wdata(core_wdata), .busy(busy), .done(done),
      .timeout_err(timeout_err), .rdata(rdata), .mem(mif)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
      end
   endtask

   // ---------------- behavioural memory controller ----------------
   logic [15:0] memory [256];
   int  rsp_delay = 1;    // cycles from request pulse to MReady; 0 = never answer
   bit  rsp_stale = 1'b0; // also raise MReady during the request (ISSUE) cycle
   bit  pend = 1'b0;
   bit  pend_store = 1'b0;
   int  rcnt = 0;

   initial begin
      for (int i = 0; i < 256; i++) memory[i] = 16'h0000;
      memory[11] = 16'h1234;
      memory[30] = 16'h00AB;
      memory[40] = 16'h4040;
      memory[50] = 16'h5050;
      mif.MReady = 1'b0;
      for (int i = 0; i < NC; i++) mif.q[i] = 16'hDEAD;
      forever begin
         @(negedge clk);
         mif.MReady = 1'b0;
         for (int i = 0; i < NC; i++) mif.q[i] = 16'hDEAD;
         if (pend) begin
            if (rcnt == 1) begin
               mif.MReady = 1'b1;
               pend = 1'b0;
               for (int i = 0; i < NC; i++) begin
                  if (mif.en[i]) begin
                     if (pend_store) memory[mif.addr[i][7:0]] = mif.data[i];
                     else mif.q[i] = memory[mif.addr[i][7:0]];
                  end
               end
            end else begin
               rcnt--;
            end
         end
         if (mif.MRead || mif.MWrite) begin
            if (rsp_delay > 0) begin
               pend = 1'b1;
               rcnt = rsp_delay;
               pend_store = mif.MWrite;
            end
            if (rsp_stale) mif.MReady = 1'b1;
         end
      end
   end

   // ---------------- reference model (transaction timeline) ----------------
   bit           m_active = 1'b0;
   int           m_acc = 0;
   int           m_done_at = -1;
   bit           m_store = 1'b0;
   logic [NC-1:0] m_mask;
   logic         e_busy, e_done, e_terr, e_mread, e_mwrite;
   logic [NC-1:0] e_en;
   lane_t        e_addr, e_data, e_rdata;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            m_active = 1'b0; m_done_at = -1;
            e_busy = 1'b0; e_done = 1'b0; e_terr = 1'b0; e_mread = 1'b0; e_mwrite = 1'b0;
            e_en = 4'b0000;
            for (int i = 0; i < NC; i++) begin
               e_addr[i] = 16'h0000; e_data[i] = 16'h0000; e_rdata[i] = 16'h0000;
            end
         end else if (m_active && m_done_at == cyc - 1) begin
            m_active = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         end else if (!m_active) begin
            if (start) begin
               m_active = 1'b1; m_acc = cyc; m_store = is_store; m_mask = core_en;
               e_terr = 1'b0; e_busy = 1'b1; e_addr = core_addr; e_data = core_wdata;
               if (core_en == 4'b0000) begin
                  m_done_at = cyc; e_done = 1'b1; e_mread = 1'b0; e_mwrite = 1'b0;
               end else begin
                  m_done_at = -1; e_en = core_en; e_mread = !is_store; e_mwrite = is_store;
               end
            end
         end else begin
            e_mread = 1'b0; e_mwrite = 1'b0;
            // Only MReady sampled after the request cycle counts; deadline is TO wait cycles.
            if (cyc - 1 > m_acc && mif.MReady) begin
               m_done_at = cyc; e_done = 1'b1; e_en = 4'b0000;
               if (!m_store)
                  for (int i = 0; i < NC; i++) if (m_mask[i]) e_rdata[i] = mif.q[i];
            end else if (cyc - 1 == m_acc + TO) begin
               m_done_at = cyc; e_done = 1'b1; e_en = 4'b0000; e_terr = 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare and event monitor ----------------
   int n_mread = 0, n_mwrite = 0, n_busy = 0, n_done = 0;
   int mread_cyc[$];
   int done_cyc[$];

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("timeout_err", timeout_err, e_terr);
            chk("MRead", mif.MRead, e_mread);
            chk("MWrite", mif.MWrite, e_mwrite);
            chk("en", mif.en, e_en);
            for (int i = 0; i < NC; i++) begin
               chk("addr", mif.addr[i], e_addr[i]);
               chk("data", mif.data[i], e_data[i]);
               chk("rdata", rdata[i], e_rdata[i]);
            end
         end
         if (mif.MRead) begin n_mread++; mread_cyc.push_back(cyc); end
         if (mif.MWrite) n_mwrite++;
         if (busy) n_busy++;
         if (done) begin n_done++; done_cyc.push_back(cyc); end
      end
   end

   task automatic run_txn(input logic st, input logic [NC-1:0] m, input lane_t ad, input lane_t wd,
                          input int dly, output int acc, output int dcyc);
      @(negedge clk);
      rsp_delay = dly; start = 1'b1; is_store = st; core_en = m; core_addr = ad; core_wdata = wd;
      @(posedge clk);
      #1 acc = cyc;
      @(negedge clk);
      start = 1'b0; is_store = ~st; core_en = ~m;
      for (int i = 0; i < NC; i++) begin core_addr[i] = 16'hBEEF; core_wdata[i] = 16'hFACE; end
      dcyc = -1;
      for (int n = 0; n < 100; n++) begin
         if (done) begin dcyc = cyc; break; end
         @(negedge clk);
      end
      chk("done_within_bound", (dcyc >= 0), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   lane_t la, lw;
   int a, d, m0, w0, b0, dn0, base, dbase;

   initial begin
      for (int i = 0; i < NC; i++) begin core_addr[i] = 16'h0000; core_wdata[i] = 16'h0000; lw[i] = 16'h0000; end
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", busy, 32'd0);
      chk("rst_done", done, 32'd0);
      chk("rst_MRead", mif.MRead, 32'd0);
      chk("rst_en", mif.en, 32'd0);
      chk("rst_rdata0", rdata[0], 32'd0);

      // Load, single lane, MReady three cycles after MRead
      la = '{16'd10, 16'd11, 16'd12, 16'd13};
      m0 = n_mread; w0 = n_mwrite;
      run_txn(1'b0, 4'b0010, la, lw, 3, a, d);
      chk("t1_latency", d - a, 32'd4);
      chk("t1_mread_pulses", n_mread - m0, 32'd1);
      chk("t1_mwrite_pulses", n_mwrite - w0, 32'd0);
      chk("t1_rdata1", rdata[1], 32'h1234);
      chk("t1_rdata0", rdata[0], 32'h0000);
      chk("t1_rdata3", rdata[3], 32'h0000);

      // Store, all lanes, then read back at minimum latency
      la = '{16'd20, 16'd21, 16'd22, 16'd23};
      lw = '{16'd9, 16'd20, 16'd55, 16'd24};
      m0 = n_mread; w0 = n_mwrite;
      run_txn(1'b1, 4'b1111, la, lw, 2, a, d);
      chk("t2_latency", d - a, 32'd3);
      chk("t2_mwrite_pulses", n_mwrite - w0, 32'd1);
      chk("t2_mread_pulses", n_mread - m0, 32'd0);
      chk("t2_rdata1_kept", rdata[1], 32'h1234);
      run_txn(1'b0, 4'b1111, la, lw, 1, a, d);
      chk("t2_rb_latency", d - a, 32'd2);
      chk("t2_rb0", rdata[0], 32'd9);
      chk("t2_rb1", rdata[1], 32'd20);
      chk("t2_rb2", rdata[2], 32'd55);
      chk("t2_rb3", rdata[3], 32'd24);

      // Empty mask: no request pulse, done right after acceptance
      m0 = n_mread; w0 = n_mwrite; b0 = n_busy;
      run_txn(1'b0, 4'b0000, la, lw, 1, a, d);
      chk("t3_latency", d - a, 32'd0);
      @(negedge clk);
      chk("t3_busy_cycles", n_busy - b0, 32'd1);
      chk("t3_no_requests", (n_mread - m0) + (n_mwrite - w0), 32'd0);

      // Timeout with no MReady, then next start clears the error
      run_txn(1'b0, 4'b1111, la, lw, 0, a, d);
      chk("t4_latency", d - a, 32'd17);
      chk("t4_timeout_err", timeout_err, 32'd1);
      chk("t4_rdata0_kept", rdata[0], 32'd9);
      chk("t4_rdata3_kept", rdata[3], 32'd24);
      la = '{16'd30, 16'd0, 16'd0, 16'd0};
      run_txn(1'b0, 4'b0001, la, lw, 2, a, d);
      chk("t4_err_cleared", timeout_err, 32'd0);
      chk("t4_rdata0_new", rdata[0], 32'h00AB);

      // Reset in the second WAIT cycle abandons the request
      la = '{16'd0, 16'd0, 16'd0, 16'd40};
      @(negedge clk);
      rsp_delay = 5; start = 1'b1; is_store = 1'b0; core_en = 4'b1000; core_addr = la;
      @(posedge clk);
      #1 a = cyc;
      dn0 = n_done;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("t5_busy", busy, 32'd0);
      chk("t5_done", done, 32'd0);
      chk("t5_en", mif.en, 32'd0);
      chk("t5_addr3", mif.addr[3], 32'd0);
      chk("t5_rdata0", rdata[0], 32'd0);
      repeat (8) @(negedge clk);
      chk("t5_no_done", n_done - dn0, 32'd0);
      run_txn(1'b0, 4'b1000, la, lw, 2, a, d);
      chk("t5_recover_latency", d - a, 32'd3);
      chk("t5_recover_rdata3", rdata[3], 32'h4040);

      // start held high: back-to-back loads with a stale MReady during each request cycle
      la = '{16'd0, 16'd0, 16'd50, 16'd0};
      @(negedge clk);
      base = mread_cyc.size(); dbase = done_cyc.size();
      rsp_delay = 2; rsp_stale = 1'b1;
      start = 1'b1; is_store = 1'b0; core_en = 4'b0100; core_addr = la;
      for (int n = 0; n < 60 && mread_cyc.size() < base + 2; n++) @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 60 && done_cyc.size() < dbase + 2; n++) @(negedge clk);
      rsp_stale = 1'b0;
      chk("t6_two_reads", mread_cyc.size() - base, 32'd2);
      chk("t6_two_dones", done_cyc.size() - dbase, 32'd2);
      if (mread_cyc.size() >= base + 2 && done_cyc.size() >= dbase + 1) begin
         chk("t6_read_spacing", mread_cyc[base + 1] - mread_cyc[base], 32'd5);
         chk("t6_stale_ignored", done_cyc[dbase] - mread_cyc[base], 32'd3);
      end
      chk("t6_rdata2", rdata[2], 32'h5050);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_request_issuer.md
Name: mem_request_issuer

Overview:
- Initiator end of the MRead/MWrite/MReady memory handshake used by the N-core memory controller.
- Sits between the GPU control unit (load/store execute stage) and the memory controller.
- Latches one load/store request per core lane and emits a single-cycle MRead or MWrite pulse.
- Holds en/addr/data stable until MReady, captures per-core read data, then reports completion, with a stall (busy) and a timeout error.

Parameters:
- N_CORES, 4 (`N_CORES): number of core lanes.
- ADDR_W, 16: address width per lane.
- DATA_W, 16: data width per lane.
- TIMEOUT_CYCLES, 64: WAIT cycles without MReady before abort; must be ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request from control unit; sampled only in IDLE.
- is_store  in  1  1 = store (MWrite), 0 = load (MRead).
- core_en  in  N_CORES  per-lane participation mask.
- core_addr  in  ADDR_W x N_CORES  per-lane address (unpacked array).
- core_wdata  in  DATA_W x N_CORES  per-lane store data.
- busy  out  1  high whenever state != IDLE; stalls the PC.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  set on timeout; cleared on next accepted start.
- rdata  out  DATA_W x N_CORES  per-lane load result registers.
- MRead  out  1  read request pulse to memory controller.
- MWrite  out  1  write request pulse to memory controller.
- MReady  in  1  controller completion, level-sampled.
- en  out  N_CORES  lane mask to controller.
- addr  out  ADDR_W x N_CORES  lane addresses to controller.
- data  out  DATA_W x N_CORES  lane write data to controller.
- q  in  DATA_W x N_CORES  lane read data from controller.

Behaviour:
- All outputs are registered. Reset is synchronous and active-high, and the polarity and synchronicity are fixed.
- Reset values: state = IDLE; busy, done, timeout_err, MRead, MWrite = 0; en = 0; addr, data, rdata all lanes = 0; wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On start = 1 at edge t, latch is_store, core_en, core_addr, core_wdata, and clear timeout_err.
  - If core_en == 0, go to DONE directly; no MRead/MWrite is ever pulsed.
  - Otherwise go to ISSUE.
- ISSUE (cycle t+1):
  - MRead = ~is_store and MWrite = is_store, high for exactly this one cycle.
  - en = latched mask; addr and data = latched values.
  - Wait counter cleared. Always go to WAIT.
  - MReady seen during ISSUE is stale and ignored.
- WAIT:
  - en, addr and data are held stable; MRead = MWrite = 0; counter increments each cycle.
  - If MReady = 1 at an edge:
    - For a load, rdata[i] <= q[i] for every i with latched en[i] = 1; lanes with en[i] = 0 keep their old rdata.
    - For a store, rdata is unchanged.
    - Go to DONE.
  - If the counter reaches TIMEOUT_CYCLES - 1 with MReady = 0: set timeout_err = 1, leave rdata unchanged, go to DONE.
  - If MReady and timeout occur at the same edge, MReady wins: capture data, no error.
- DONE:
  - done = 1 for one cycle; en = 0.
  - start is ignored. Next state is IDLE.
- Latency and throughput:
  - With MReady sampled high at edge e, done is high in the cycle following e.
  - Minimum start-to-done latency is 3 cycles.
  - With start held high, requests run back to back with one IDLE cycle between them.
- busy = (state != IDLE), registered, so it is high from the cycle after start is accepted through DONE.
- Reset asserted mid-transaction (ISSUE/WAIT/DONE): the transaction is abandoned, all outputs return to reset values on that edge, and no done pulse is produced.
- Input changes on core_* or is_store after acceptance have no effect until the next start.

Test Plan:
- Load, mask 4'b0010, addr {10,11,12,13}, rdata preloaded 0; controller returns q[1] = 16'h1234 with MReady 3 cycles after MRead -> exactly one MRead cycle, MWrite = 0; en = 0010 and addr stable through WAIT; rdata[1] = 16'h1234, other lanes 0; done 1 cycle after MReady edge.
- Store, mask 4'b1111, addr {20,21,22,23}, wdata {9,20,55,24} -> one MWrite cycle, data held through WAIT, rdata unchanged, done pulses; a DataMemory read-back of addresses 20..23 returns 9, 20, 55, 24.
- Empty mask 4'b0000, start = 1 -> MRead and MWrite never assert; done in the 2nd cycle after start; busy high for 1 cycle.
- TIMEOUT_CYCLES = 16, MReady tied 0 -> timeout_err = 1 after 16 WAIT cycles, done pulses, rdata unchanged; next start clears timeout_err.
- Reset pulsed in the 2nd WAIT cycle -> all outputs 0 on the next edge, no done pulse; a new request afterwards completes normally.
- start held high, two loads -> two MRead pulses separated by ISSUE/WAIT/DONE/IDLE spacing; MReady already high during ISSUE is ignored (no early completion).
